icache_fetch_arbiter: RTL and testbench

ICACHE_FETCH_ARBITER -- requirements
Module: icache_fetch_arbiter

---
 rtl/icache_fetch_arbiter_if.sv | 35 +++
 rtl/icache_fetch_arbiter.sv | 99 +++++++++
 tb/tb_icache_fetch_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_arbiter_if.sv
// Fetch-side bus bundle: two requesting ways and one I-cache port.
// The arbiter takes the slave view. The ways and the cache model take the master view.
interface icache_fetch_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              way0_request_i;
    logic [ADDR_W-1:0] way0_instAddr_i;
    logic              way0_dataOk_o;
    logic [INST_W-1:0] way0_inst_o;

    logic              way1_request_i;
    logic [ADDR_W-1:0] way1_instAddr_i;
    logic              way1_dataOk_o;
    logic [INST_W-1:0] way1_inst_o;

    logic              icache_request_o;
    logic [ADDR_W-1:0] icache_instAddr_o;
    logic              icache_dataOk_i;
    logic [INST_W-1:0] icache_inst_i;

    modport slave (
        input  way0_request_i, way0_instAddr_i, way1_request_i, way1_instAddr_i,
               icache_dataOk_i, icache_inst_i,
        output way0_dataOk_o, way0_inst_o, way1_dataOk_o, way1_inst_o,
               icache_request_o, icache_instAddr_o
    );

    modport master (
        output way0_request_i, way0_instAddr_i, way1_request_i, way1_instAddr_i,
               icache_dataOk_i, icache_inst_i,
        input  way0_dataOk_o, way0_inst_o, way1_dataOk_o, way1_inst_o,
               icache_request_o, icache_instAddr_o
    );
endinterface

// File: rtl/icache_fetch_arbiter.sv
// Round-robin arbiter that shares one I-cache port between two fetch ways.
// Only one transaction is outstanding at a time. A flush drains the response that is already in flight.
module icache_fetch_arbiter #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    output logic                  owner_o,
    output logic                  busy_o,
    output logic                  err_o,
    icache_fetch_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              deliver;
    logic              grant;

    // NOTE: every variable gets a default before the case, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        err_d   = err_q;
        deliver = 1'b0;
        grant   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A response with nothing outstanding is a protocol error and its data is dropped.
                if (bus.icache_dataOk_i) err_d = 1'b1;
                if (!flush_i && (bus.way0_request_i || bus.way1_request_i)) begin
                    grant   = (bus.way0_request_i && bus.way1_request_i) ? rr_q : bus.way1_request_i;
                    owner_d = grant;
                    addr_d  = grant ? bus.way1_instAddr_i : bus.way0_instAddr_i;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.icache_dataOk_i) begin
                    deliver = !flush_i;
                    rr_d    = ~owner_q;
                    state_d = ST_IDLE;
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.icache_dataOk_i) begin
                    rr_d    = ~owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign bus.icache_request_o  = (state_q != ST_IDLE);
    assign bus.icache_instAddr_o = addr_q;

    assign bus.way0_dataOk_o = deliver && !owner_q;
    assign bus.way1_dataOk_o = deliver &&  owner_q;
    assign bus.way0_inst_o   = bus.way0_dataOk_o ? bus.icache_inst_i : '0;
    assign bus.way1_inst_o   = bus.way1_dataOk_o ? bus.icache_inst_i : '0;

    assign owner_o = owner_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign err_o   = err_q;

endmodule

// File: tb/tb_icache_fetch_arbiter.sv
// Directed bench: a per-cycle vector table with hand-computed outputs,
// followed by a short handshake sequence that uses bounded waits.
module tb_icache_fetch_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic flush_i;
    logic owner_o, busy_o, err_o;

    icache_fetch_arbiter_if #(.ADDR_W(32), .INST_W(32)) bus ();

    icache_fetch_arbiter #(.ADDR_W(32), .INST_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush_i),
        .owner_o (owner_o),
        .busy_o  (busy_o),
        .err_o   (err_o),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ireq;
        logic [31:0] iaddr;
        logic        ok0;
        logic [31:0] inst0;
        logic        ok1;
        logic [31:0] inst1;
        logic        owner;
        logic        busy;
        logic        err;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        fl;
        logic        r0;
        logic [31:0] a0;
        logic        r1;
        logic [31:0] a1;
        logic        ok;
        logic [31:0] inst;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t v(
        logic rst, logic fl, logic r0, logic [31:0] a0, logic r1, logic [31:0] a1,
        logic ok, logic [31:0] inst,
        logic e_req, logic [31:0] e_addr, logic e_ok0, logic [31:0] e_i0,
        logic e_ok1, logic [31:0] e_i1, logic e_own, logic e_busy, logic e_err);
        vec_t r;
        r.rst = rst; r.fl = fl; r.r0 = r0; r.a0 = a0; r.r1 = r1; r.a1 = a1;
        r.ok = ok; r.inst = inst;
        r.exp.ireq = e_req; r.exp.iaddr = e_addr; r.exp.ok0 = e_ok0; r.exp.inst0 = e_i0;
        r.exp.ok1 = e_ok1; r.exp.inst1 = e_i1; r.exp.owner = e_own; r.exp.busy = e_busy;
        r.exp.err = e_err;
        return r;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.ireq  = bus.icache_request_o;
        o.iaddr = bus.icache_instAddr_o;
        o.ok0   = bus.way0_dataOk_o;
        o.inst0 = bus.way0_inst_o;
        o.ok1   = bus.way1_dataOk_o;
        o.inst1 = bus.way1_inst_o;
        o.owner = owner_o;
        o.busy  = busy_o;
        o.err   = err_o;
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        reset                   = x.rst;
        flush_i                 = x.fl;
        bus.way0_request_i      = x.r0;
        bus.way0_instAddr_i     = x.a0;
        bus.way1_request_i      = x.r1;
        bus.way1_instAddr_i     = x.a1;
        bus.icache_dataOk_i     = x.ok;
        bus.icache_inst_i       = x.inst;
    endtask

    // Advances one cycle at a time until the cache request rises, giving up after 5 cycles.
    task automatic wait_ireq(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.icache_request_o) seen = 1'b1;
        end
    endtask

    initial begin
        vec_t h;
        logic seen;

        //           rst fl r0 a0          r1 a1          ok inst           | req addr        ok0 i0            ok1 i1            own bsy err
        vecs.push_back(v(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0, 0)); // 0 reset state
        vecs.push_back(v(0, 0, 1, 32'h100, 1, 32'h200, 0, 32'h0,          0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0, 0)); // 1 both request, rr=0
        vecs.push_back(v(0, 0, 1, 32'h100, 1, 32'h200, 0, 32'h0,          1, 32'h100, 0, 32'h0,        0, 32'h0,        0, 1, 0)); // 2 way0 wins
        vecs.push_back(v(0, 0, 1, 32'h100, 1, 32'h200, 1, 32'h11110000,   1, 32'h100, 1, 32'h11110000, 0, 32'h0,        0, 1, 0)); // 3 way0 served
        vecs.push_back(v(0, 0, 1, 32'h104, 1, 32'h200, 0, 32'h0,          0, 32'h100, 0, 32'h0,        0, 32'h0,        0, 0, 0)); // 4 idle, rr=1
        vecs.push_back(v(0, 0, 1, 32'h104, 1, 32'h999, 0, 32'h0,          1, 32'h200, 0, 32'h0,        0, 32'h0,        1, 1, 0)); // 5 way1 wins, addr held
        vecs.push_back(v(0, 0, 1, 32'h104, 1, 32'h999, 1, 32'h22220000,   1, 32'h200, 0, 32'h0,        1, 32'h22220000, 1, 1, 0)); // 6 way1 served
        vecs.push_back(v(0, 0, 1, 32'h104, 0, 32'h0,   0, 32'h0,          0, 32'h200, 0, 32'h0,        0, 32'h0,        1, 0, 0)); // 7 grant way0
        vecs.push_back(v(0, 0, 1, 32'h104, 0, 32'h0,   1, 32'h0104C0DE,   1, 32'h104, 1, 32'h0104C0DE, 0, 32'h0,        0, 1, 0)); // 8 fast reply
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 32'h80,  0, 32'h0,          0, 32'h104, 0, 32'h0,        0, 32'h0,        0, 0, 0)); // 9 only way1
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 32'h80,  0, 32'h0,          1, 32'h80,  0, 32'h0,        0, 32'h0,        1, 1, 0)); // 10
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 32'h80,  1, 32'hDEADBEEF,   1, 32'h80,  0, 32'h0,        1, 32'hDEADBEEF, 1, 1, 0)); // 11 deadbeef
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hDEADBEEF,   0, 32'h80,  0, 32'h0,        0, 32'h0,        1, 0, 0)); // 12 inst gated
        vecs.push_back(v(0, 0, 1, 32'h300, 0, 32'h0,   0, 32'h0,          0, 32'h80,  0, 32'h0,        0, 32'h0,        1, 0, 0)); // 13 grant way0
        vecs.push_back(v(0, 1, 1, 32'h300, 0, 32'h0,   0, 32'h0,          1, 32'h300, 0, 32'h0,        0, 32'h0,        0, 1, 0)); // 14 flush in WAIT
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h300, 0, 32'h0,        0, 32'h0,        0, 1, 0)); // 15 DRAIN
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h300, 0, 32'h0,        0, 32'h0,        0, 1, 0)); // 16 DRAIN
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h33333333,   1, 32'h300, 0, 32'h0,        0, 32'h0,        0, 1, 0)); // 17 drained, no pulse
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          0, 32'h300, 0, 32'h0,        0, 32'h0,        0, 0, 0)); // 18 busy dropped
        vecs.push_back(v(0, 0, 1, 32'h400, 1, 32'h500, 0, 32'h0,          0, 32'h300, 0, 32'h0,        0, 32'h0,        0, 0, 0)); // 19 rr=1 -> way1
        vecs.push_back(v(0, 1, 1, 32'h400, 1, 32'h500, 1, 32'h44444444,   1, 32'h500, 0, 32'h0,        0, 32'h0,        1, 1, 0)); // 20 flush+ok
        vecs.push_back(v(0, 0, 1, 32'h400, 1, 32'h500, 0, 32'h0,          0, 32'h500, 0, 32'h0,        0, 32'h0,        1, 0, 0)); // 21 idle, rr toggled
        vecs.push_back(v(0, 0, 1, 32'h400, 1, 32'h500, 0, 32'h0,          1, 32'h400, 0, 32'h0,        0, 32'h0,        0, 1, 0)); // 22 way0 wins
        vecs.push_back(v(0, 0, 1, 32'h400, 1, 32'h500, 1, 32'h55555555,   1, 32'h400, 1, 32'h55555555, 0, 32'h0,        0, 1, 0)); // 23
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h66666666,   0, 32'h400, 0, 32'h0,        0, 32'h0,        0, 0, 0)); // 24 stray ok
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          0, 32'h400, 0, 32'h0,        0, 32'h0,        0, 0, 1)); // 25 err sticky
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 32'h600, 0, 32'h0,          0, 32'h400, 0, 32'h0,        0, 32'h0,        0, 0, 1)); // 26 grant way1
        vecs.push_back(v(1, 0, 0, 32'h0,   1, 32'h600, 0, 32'h0,          1, 32'h600, 0, 32'h0,        0, 32'h0,        1, 1, 1)); // 27 reset mid-WAIT
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h77777777,   0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0, 0)); // 28 all cleared
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0, 1)); // 29 late ok -> err
        vecs.push_back(v(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0, 1)); // 30 reset
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0, 0)); // 31 err cleared
        vecs.push_back(v(0, 1, 1, 32'h700, 0, 32'h0,   0, 32'h0,          0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0, 0)); // 32 flush in IDLE
        vecs.push_back(v(0, 0, 1, 32'h700, 0, 32'h0,   0, 32'h0,          0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0, 0)); // 33 no grant yet
        vecs.push_back(v(0, 0, 1, 32'h700, 0, 32'h0,   0, 32'h0,          1, 32'h700, 0, 32'h0,        0, 32'h0,        0, 1, 0)); // 34 granted

        drive(vecs[0]);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d", i), sample(), vecs[i].exp);
        end

        // Complete the way0 transaction at 0x700, then run a way1 fetch through bounded waits.
        h = vecs[vecs.size()-1];
        @(negedge clk);
        h.ok = 1'b1; h.inst = 32'hA5A5A5A5;
        drive(h);
        #1;
        check("way0_pulse", {bus.way0_dataOk_o, bus.way0_inst_o, bus.way1_dataOk_o}, {1'b1, 32'hA5A5A5A5, 1'b0});

        @(negedge clk);
        h.ok = 1'b0; h.r0 = 1'b0; h.r1 = 1'b1; h.a1 = 32'h800;
        drive(h);
        wait_ireq(seen);
        check("way1_req_seen", seen, 1'b1);
        check("way1_req_addr", {owner_o, bus.icache_instAddr_o}, {1'b1, 32'h800});

        @(negedge clk);
        h.ok = 1'b1; h.inst = 32'h0BADF00D;
        drive(h);
        #1;
        check("way1_pulse", {bus.way1_dataOk_o, bus.way1_inst_o, bus.way0_dataOk_o}, {1'b1, 32'h0BADF00D, 1'b0});

        @(negedge clk);
        h.ok = 1'b0; h.r1 = 1'b0;
        drive(h);
        #1;
        check("way1_pulse_end", {bus.way1_dataOk_o, busy_o, bus.icache_request_o}, {1'b0, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
